// File: rtl/hex_scan_display_if.sv
// Signal bundle between the reversible counter and the hex scan display stage.
// The master drives the counter-side levels; the slave (display) drives the anode and segment lines.
interface hex_scan_display_if;
   logic [15:0] cnt;
   logic        rc;
   logic        s;
   logic        blank_lz;
   logic [3:0]  an;
   logic [7:0]  seg;

   modport master (output cnt, rc, s, blank_lz, input an, seg);
   modport slave  (input cnt, rc, s, blank_lz, output an, seg);
endinterface

// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display for a 16-bit counter value, with direction and
// stretched-wrap status shown on the decimal points. Outputs are registered.
module hex_scan_display #(
   parameter int SCAN_DIV    = 17,
   parameter int WRAP_FRAMES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   hex_scan_display_if.slave   bus
);

   localparam logic [7:0] WRAP_LOAD = 8'(WRAP_FRAMES);

   logic [SCAN_DIV-1:0] pre, pre_nxt;
   logic [1:0]          idx, idx_nxt;
   logic [15:0]         disp, disp_nxt;
   logic [7:0]          whold, whold_nxt;
   logic                s_q, s_q_nxt;
   logic [3:0]          an_nxt;
   logic [7:0]          seg_nxt;

   logic                tick;
   logic                frame_start;
   logic [3:0]          digit;
   logic                blank;
   logic                dp;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'h0:    r = 7'b1000000;
         4'h1:    r = 7'b1111001;
         4'h2:    r = 7'b0100100;
         4'h3:    r = 7'b0110000;
         4'h4:    r = 7'b0011001;
         4'h5:    r = 7'b0010010;
         4'h6:    r = 7'b0000010;
         4'h7:    r = 7'b1111000;
         4'h8:    r = 7'b0000000;
         4'h9:    r = 7'b0010000;
         4'hA:    r = 7'b0001000;
         4'hB:    r = 7'b0000011;
         4'hC:    r = 7'b1000110;
         4'hD:    r = 7'b0100001;
         4'hE:    r = 7'b0000110;
         default: r = 7'b0001110;
      endcase
      return r;
   endfunction

   // Next-state values; the output registers are fed from these so the display
   // reflects the new digit and newly latched value on the same edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      pre_nxt   = pre + SCAN_DIV'(1);
      tick      = &pre;
      frame_start = tick && (idx == 2'd3);
      idx_nxt   = tick ? idx + 2'd1 : idx;
      disp_nxt  = frame_start ? bus.cnt : disp;
      s_q_nxt   = bus.s;

      whold_nxt = whold;
      if (bus.rc)
         whold_nxt = WRAP_LOAD;
      else if (frame_start && (whold != 8'd0))
         whold_nxt = whold - 8'd1;
   end

   // Digit selection, leading-zero blanking and decimal-point status.
   always_comb begin
      digit = 4'h0;
      blank = 1'b0;
      dp    = 1'b1;
      case (idx_nxt)
         2'd0: begin
            digit = disp_nxt[3:0];
            dp    = (whold_nxt == 8'd0);
         end
         2'd1: begin
            digit = disp_nxt[7:4];
            blank = (disp_nxt[15:4] == 12'h000);
         end
         2'd2: begin
            digit = disp_nxt[11:8];
            blank = (disp_nxt[15:8] == 8'h00);
         end
         default: begin
            digit = disp_nxt[15:12];
            blank = (disp_nxt[15:12] == 4'h0);
            dp    = ~s_q_nxt;
         end
      endcase
      blank   = blank && bus.blank_lz;
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = {dp, blank ? 7'b1111111 : hex7(digit)};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         pre     <= '0;
         idx     <= 2'd0;
         disp    <= 16'h0000;
         whold   <= 8'd0;
         s_q     <= 1'b0;
         bus.an  <= 4'b1110;
         bus.seg <= 8'b11000000;
      end else begin
         pre     <= pre_nxt;
         idx     <= idx_nxt;
         disp    <= disp_nxt;
         whold   <= whold_nxt;
         s_q     <= s_q_nxt;
         bus.an  <= an_nxt;
         bus.seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display with a 4-cycle digit dwell and a 2-frame wrap stretch.
// Edge numbering restarts after each reset so frame starts fall on cyc % 16 == 15.
module tb_hex_scan_display;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;

   hex_scan_display_if bus ();

   hex_scan_display #(.SCAN_DIV(2), .WRAP_FRAMES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]     cnt;
      logic            blz;
      logic            s;
      logic [3:0][6:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_frame();
      do step(); while ((cyc % 16) != 15);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;

      //               cnt       blz   s     d3          d2          d1          d0
      vecs[0] = '{16'hA5C3, 1'b0, 1'b0, {7'b0001000, 7'b0010010, 7'b1000110, 7'b0110000}};
      vecs[1] = '{16'h0007, 1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
      vecs[2] = '{16'h0000, 1'b1, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
      vecs[3] = '{16'h0000, 1'b0, 1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
      vecs[4] = '{16'h0F00, 1'b1, 1'b0, {7'b1111111, 7'b0001110, 7'b1000000, 7'b1000000}};
      vecs[5] = '{16'h1234, 1'b1, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
      vecs[6] = '{16'h89BE, 1'b0, 1'b0, {7'b0000000, 7'b0010000, 7'b0000011, 7'b0000110}};
      vecs[7] = '{16'h6D0F, 1'b0, 1'b1, {7'b0000010, 7'b0100001, 7'b1000000, 7'b0001110}};

      // Reset with a nonzero count present.
      rst_n        = 1'b0;
      bus.cnt      = 16'h1234;
      bus.rc       = 1'b0;
      bus.s        = 1'b0;
      bus.blank_lz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("reset_an_%0d", i), {4'h0, bus.an}, 8'b00001110);
         check($sformatf("reset_seg_%0d", i), bus.seg, 8'b11000000);
      end
      rst_n = 1'b1;
      cyc   = -1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("post_reset_an_%0d", i), {4'h0, bus.an}, 8'b00001110);
      end
      step();
      check("first_tick_an", {4'h0, bus.an}, 8'b00001101);
      check("first_tick_seg", bus.seg, 8'b11000000);

      // Table: value latched at frame start, cnt scrambled mid-frame must not show.
      for (int v = 0; v < 8; v++) begin
         bus.cnt      = vecs[v].cnt;
         bus.blank_lz = vecs[v].blz;
         bus.s        = vecs[v].s;
         wait_frame();
         for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (4) step();
            check($sformatf("v%0d_d%0d_an", v, d), {4'h0, bus.an}, {4'h0, ~(4'b0001 << d)});
            check($sformatf("v%0d_d%0d_seg", v, d), {1'b0, bus.seg[6:0]}, {1'b0, vecs[v].exp[d]});
            check($sformatf("v%0d_d%0d_dp", v, d), {7'h0, bus.seg[7]},
                  {7'h0, (d == 3) ? ~vecs[v].s : 1'b1});
            if (d == 0) bus.cnt = ~vecs[v].cnt;
         end
      end

      // Direction DP follows s one cycle later while digit 3 is active.
      bus.cnt      = 16'h4321;
      bus.blank_lz = 1'b0;
      bus.s        = 1'b1;
      wait_frame();
      repeat (12) step();
      check("dir_an_d3", {4'h0, bus.an}, 8'b00000111);
      check("dir_dp_s1", {7'h0, bus.seg[7]}, 8'h00);
      bus.s = 1'b0;
      step();
      check("dir_an_still_d3", {4'h0, bus.an}, 8'b00000111);
      check("dir_dp_s0", {7'h0, bus.seg[7]}, 8'h01);
      bus.s = 1'b1;
      step();
      check("dir_dp_s1_again", {7'h0, bus.seg[7]}, 8'h00);
      bus.s = 1'b0;

      // Single-cycle rc mid-frame: whold 2, then 1 at next frame start, 0 at the one after.
      wait_frame();
      repeat (5) step();
      bus.rc = 1'b1;
      step();
      bus.rc = 1'b0;
      check("wrap_d1_dp_off", {7'h0, bus.seg[7]}, 8'h01);
      wait_frame();
      check("wrap_f1_dp_lit", {7'h0, bus.seg[7]}, 8'h00);
      check("wrap_f1_digit", {1'b0, bus.seg[6:0]}, 8'b01111001);
      wait_frame();
      check("wrap_f2_dp_off", {7'h0, bus.seg[7]}, 8'h01);
      wait_frame();
      check("wrap_f3_dp_off", {7'h0, bus.seg[7]}, 8'h01);

      // Reload on the frame-start edge wins over the decrement from 1.
      wait_frame();
      repeat (5) step();
      bus.rc = 1'b1;
      step();
      bus.rc = 1'b0;
      wait_frame();
      check("reload_f1_dp_lit", {7'h0, bus.seg[7]}, 8'h00);
      repeat (15) step();
      bus.rc = 1'b1;
      step();
      bus.rc = 1'b0;
      check("reload_fs_an", {4'h0, bus.an}, 8'b00001110);
      check("reload_fs_dp_lit", {7'h0, bus.seg[7]}, 8'h00);
      wait_frame();
      check("reload_f2_dp_lit", {7'h0, bus.seg[7]}, 8'h00);
      wait_frame();
      check("reload_f3_dp_off", {7'h0, bus.seg[7]}, 8'h01);

      // Reset mid-frame discards latched value and pending wrap indication.
      bus.cnt = 16'hBEEF;
      wait_frame();
      check("pre_rst_digit", bus.seg, 8'b10001110);
      repeat (5) step();
      bus.rc = 1'b1;
      step();
      bus.rc = 1'b0;
      rst_n  = 1'b0;
      step();
      check("midrst_an", {4'h0, bus.an}, 8'b00001110);
      check("midrst_seg", bus.seg, 8'b11000000);
      rst_n = 1'b1;
      cyc   = -1;
      repeat (3) step();
      check("midrst_hold_an", {4'h0, bus.an}, 8'b00001110);
      check("midrst_hold_seg", bus.seg, 8'b11000000);
      step();
      check("midrst_d1_an", {4'h0, bus.an}, 8'b00001101);
      check("midrst_d1_seg", bus.seg, 8'b11000000);
      wait_frame();
      check("midrst_relatch_seg", bus.seg, 8'b10001110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
